// File: rtl/cb_param_udl_if.sv
// Control and status bundle of one counter stage.
// The master side drives CE/UP/L/D/CLR_OVF; the counter (slave side) returns Q/TC/CEO/OVF.
interface cb_param_udl_if #(
  parameter int WIDTH = 8
);
  logic             CE;
  logic             UP;
  logic             L;
  logic [WIDTH-1:0] D;
  logic             CLR_OVF;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             CEO;
  logic             OVF;

  modport master (
    output CE, UP, L, D, CLR_OVF,
    input  Q, TC, CEO, OVF
  );

  modport slave (
    input  CE, UP, L, D, CLR_OVF,
    output Q, TC, CEO, OVF
  );
endinterface

// File: rtl/cb_param_udl.sv
// Up/down loadable modulo counter with sticky wrap flag and cascade enable out.
// Q/OVF update one edge after R/L/CE are sampled; TC/CEO are combinational; never stalls.
module cb_param_udl #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input logic           CLK,
  input logic           R,
  cb_param_udl_if.slave bus
);

  if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_cfg
    $error("cb_param_udl: MODULUS must lie in 2..2**WIDTH and WIDTH must be >= 1");
  end

  localparam logic [WIDTH-1:0] QMAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  // One extra bit so MODULUS == 2**WIDTH is representable for the load compare.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             tc;
  logic             wrap;

  always_comb begin
    tc   = bus.UP ? (q_q == QMAX) : (q_q == '0);
    wrap = tc & bus.CE & ~bus.L & ~R;
  end

  always_comb begin
    q_d = q_q;
    if (bus.L) begin
      q_d = ({1'b0, bus.D} < MOD_X) ? bus.D : QMAX;
    end else if (bus.CE) begin
      if (wrap) begin
        q_d = bus.UP ? '0 : QMAX;
      end else if (bus.UP) begin
        q_d = q_q + ONE;
      end else begin
        q_d = q_q - ONE;
      end
    end
    // A wrap in the same cycle as a clear request keeps the flag set.
    ovf_d = wrap | (ovf_q & ~bus.CLR_OVF);
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.OVF = ovf_q;
  assign bus.TC  = tc;
  assign bus.CEO = wrap;

endmodule

// File: tb/tb_cb_param_udl.sv
// Bench for cb_param_udl: a decade stage, a two-digit decade cascade and a full-range 8-bit stage,
// each compared every cycle against an integer-arithmetic model.
module tb_cb_param_udl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra, rc, rw;
  bit   chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  cb_param_udl_if #(.WIDTH(4)) ia ();
  cb_param_udl_if #(.WIDTH(4)) ic0 ();
  cb_param_udl_if #(.WIDTH(4)) ic1 ();
  cb_param_udl_if #(.WIDTH(8)) iw ();

  cb_param_udl #(.WIDTH(4), .MODULUS(10))  u_a  (.CLK(clk), .R(ra), .bus(ia));
  cb_param_udl #(.WIDTH(4), .MODULUS(10))  u_c0 (.CLK(clk), .R(rc), .bus(ic0));
  cb_param_udl #(.WIDTH(4), .MODULUS(10))  u_c1 (.CLK(clk), .R(rc), .bus(ic1));
  cb_param_udl #(.WIDTH(8), .MODULUS(256)) u_w  (.CLK(clk), .R(rw), .bus(iw));

  assign ic0.UP      = 1'b1;
  assign ic0.L       = 1'b0;
  assign ic0.D       = 4'd0;
  assign ic0.CLR_OVF = 1'b0;
  assign ic1.CE      = ic0.CEO;
  assign ic1.UP      = 1'b1;
  assign ic1.L       = 1'b0;
  assign ic1.D       = 4'd0;
  assign ic1.CLR_OVF = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: next state of one stage from its present value and inputs.
  function automatic void mstep(input int modulus, input logic r, l, ce, up, clr, input int d,
                                input int q, input int ovf, output int nq, output int novf);
    bit at_end;
    at_end = up ? (q == modulus - 1) : (q == 0);
    nq   = q;
    novf = ovf;
    if (r) begin
      nq   = 0;
      novf = 0;
    end else begin
      if (l) nq = (d < modulus) ? d : modulus - 1;
      else if (ce) nq = (q + (up ? 1 : modulus - 1)) % modulus;
      if (ce && !l && at_end) novf = 1;
      else if (clr) novf = 0;
    end
  endfunction

  int ma_q = 0, ma_ovf = 0, mw_q = 0, mw_ovf = 0;
  int mc_v = 0, mc_o0 = 0, mc_o1 = 0;

  always @(posedge clk) begin
    mstep(10, ra, ia.L, ia.CE, ia.UP, ia.CLR_OVF, int'(ia.D), ma_q, ma_ovf, ma_q, ma_ovf);
    mstep(256, rw, iw.L, iw.CE, iw.UP, iw.CLR_OVF, int'(iw.D), mw_q, mw_ovf, mw_q, mw_ovf);
    // The cascade pair is one two-digit decimal number 0..99.
    if (rc) begin
      mc_v = 0; mc_o0 = 0; mc_o1 = 0;
    end else if (ic0.CE) begin
      if (mc_v % 10 == 9) mc_o0 = 1;
      if (mc_v == 99) mc_o1 = 1;
      mc_v = (mc_v + 1) % 100;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit tca, tcw, ce0;
      tca = ia.UP ? (ma_q == 9) : (ma_q == 0);
      tcw = iw.UP ? (mw_q == 255) : (mw_q == 0);
      ce0 = ic0.CE && !rc;
      check("mdl_a_q",    ia.Q,   ma_q);
      check("mdl_a_ovf",  ia.OVF, ma_ovf);
      check("mdl_a_tc",   ia.TC,  tca);
      check("mdl_a_ceo",  ia.CEO, tca && ia.CE && !ia.L && !ra);
      check("mdl_w_q",    iw.Q,   mw_q);
      check("mdl_w_ovf",  iw.OVF, mw_ovf);
      check("mdl_w_tc",   iw.TC,  tcw);
      check("mdl_w_ceo",  iw.CEO, tcw && iw.CE && !iw.L && !rw);
      check("mdl_c0_q",   ic0.Q,  mc_v % 10);
      check("mdl_c1_q",   ic1.Q,  mc_v / 10);
      check("mdl_c0_tc",  ic0.TC, (mc_v % 10) == 9);
      check("mdl_c1_tc",  ic1.TC, (mc_v / 10) == 9);
      check("mdl_c0_ceo", ic0.CEO, ce0 && (mc_v % 10 == 9));
      check("mdl_c1_ceo", ic1.CEO, ce0 && (mc_v == 99));
      check("mdl_c0_ovf", ic0.OVF, mc_o0);
      check("mdl_c1_ovf", ic1.OVF, mc_o1);
    end
  end

  initial begin
    ra = 1'b1; rc = 1'b1; rw = 1'b1;
    ia.CE = 1'b0; ia.UP = 1'b1; ia.L = 1'b0; ia.D = '0; ia.CLR_OVF = 1'b0;
    iw.CE = 1'b0; iw.UP = 1'b1; iw.L = 1'b0; iw.D = '0; iw.CLR_OVF = 1'b0;
    ic0.CE = 1'b0;
    tick();
    chk_en = 1'b1;
    fork
      begin : thr_a
        check("rst_q", ia.Q, 0);
        check("rst_ovf", ia.OVF, 0);
        check("rst_tc_up", ia.TC, 0);
        ia.UP = 1'b0; ia.CE = 1'b1;
        #1;
        check("rst_tc_dn", ia.TC, 1);
        check("rst_ceo", ia.CEO, 0);
        ra = 1'b0; ia.UP = 1'b1;
        for (int i = 0; i < 12; i++) begin
          if (i == 9) begin
            #1;
            check("up_tc9", ia.TC, 1);
            check("up_ceo9", ia.CEO, 1);
          end
          tick();
        end
        check("up_q12", ia.Q, 2);
        check("up_ovf", ia.OVF, 1);
        ia.CE = 1'b0; ia.CLR_OVF = 1'b1; tick();
        check("clr_alone", ia.OVF, 0);
        ia.CLR_OVF = 1'b0; ia.L = 1'b1; ia.D = 4'd0; tick();
        ia.L = 1'b0; ia.UP = 1'b0; ia.CE = 1'b1;
        #1;
        check("dn_tc0", ia.TC, 1);
        tick();
        check("dn_wrap_q", ia.Q, 9);
        check("dn_wrap_ovf", ia.OVF, 1);
        repeat (4) tick();
        check("dn_q5", ia.Q, 5);
        check("dn_tc5", ia.TC, 0);
        ia.UP = 1'b1;
        #1;
        check("up_tc5", ia.TC, 0);
        tick();
        check("rev_q6", ia.Q, 6);
        ia.CE = 1'b0; ia.L = 1'b1; ia.D = 4'd7; tick();
        check("load7", ia.Q, 7);
        ia.D = 4'd13; tick();
        check("load_sat", ia.Q, 9);
        ia.L = 1'b0; ia.CLR_OVF = 1'b1; tick();
        ia.CLR_OVF = 1'b0; ia.L = 1'b1; ia.CE = 1'b1; ia.D = 4'd3;
        #1;
        check("ldtc_tc", ia.TC, 1);
        check("ldtc_ceo", ia.CEO, 0);
        tick();
        check("ldtc_q", ia.Q, 3);
        check("ldtc_ovf", ia.OVF, 0);
        ia.CE = 1'b0; ia.D = 4'd9; tick();
        ia.L = 1'b0; ia.CE = 1'b1; ia.CLR_OVF = 1'b1; tick();
        check("clrwrap_q", ia.Q, 0);
        check("clrwrap_ovf", ia.OVF, 1);
        ia.L = 1'b1; ia.CE = 1'b0; ia.CLR_OVF = 1'b0; tick();
        ia.L = 1'b0; ra = 1'b1; ia.CE = 1'b1;
        #1;
        check("rst9_ceo", ia.CEO, 0);
        tick();
        check("rst9_q", ia.Q, 0);
        check("rst9_ovf", ia.OVF, 0);
        for (int i = 0; i < 3000; i++) begin
          ra         = ($urandom_range(63) == 0);
          ia.L       = ($urandom_range(7) == 0);
          ia.CE      = ($urandom_range(3) != 0);
          ia.UP      = 1'($urandom_range(1));
          ia.D       = 4'($urandom_range(15));
          ia.CLR_OVF = ($urandom_range(15) == 0);
          tick();
        end
      end
      begin : thr_c
        rc = 1'b0; ic0.CE = 1'b1;
        for (int n = 1; n <= 120; n++) begin
          tick();
          if (n == 99) begin
            check("casc_q0_99", ic0.Q, 9);
            check("casc_q1_99", ic1.Q, 9);
            check("casc_ovf1_99", ic1.OVF, 0);
            check("casc_ceo1_99", ic1.CEO, 1);
          end
          if (n == 100) begin
            check("casc_q0_100", ic0.Q, 0);
            check("casc_q1_100", ic1.Q, 0);
            check("casc_ovf1_100", ic1.OVF, 1);
          end
        end
        for (int i = 0; i < 400; i++) begin
          rc     = ($urandom_range(99) == 0);
          ic0.CE = 1'($urandom_range(1));
          tick();
        end
      end
      begin : thr_w
        rw = 1'b0; iw.L = 1'b1; iw.D = 8'd255; tick();
        iw.L = 1'b0; iw.CE = 1'b1; iw.UP = 1'b1;
        #1;
        check("w_tc255", iw.TC, 1);
        check("w_ceo255", iw.CEO, 1);
        tick();
        check("w_wrap_up", iw.Q, 0);
        check("w_ovf", iw.OVF, 1);
        iw.UP = 1'b0;
        #1;
        check("w_tc0", iw.TC, 1);
        tick();
        check("w_wrap_dn", iw.Q, 255);
        for (int i = 0; i < 10000; i++) begin
          rw         = ($urandom_range(127) == 0);
          iw.L       = ($urandom_range(7) == 0);
          iw.CE      = ($urandom_range(3) != 0);
          iw.UP      = 1'($urandom_range(1));
          iw.D       = 8'($urandom_range(255));
          iw.CLR_OVF = ($urandom_range(15) == 0);
          tick();
        end
      end
    join
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cb_param_udl.md
# cb_param_udl

Parametrised up/down loadable cascadable counter, the generalised successor of the fixed 4-bit clock-enabled counter. It provides:
- configurable width and modulus, for binary, decade or arbitrary-modulus counting;
- run-time count direction and synchronous parallel load;
- a sticky wrap flag;
- TC/CEO outputs, so instances chain into wider or multi-digit counters (CEO of stage n drives CE of stage n+1).

## Interface

Parameters:
- WIDTH, 8: counter width in bits, at least 1.
- MODULUS, 256: count range 0..MODULUS-1. Legal range 2..2^WIDTH; elaboration fails outside it.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- R  input  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- CE  input  1  count enable.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- L  input  1  synchronous parallel load strobe.
- D  input  WIDTH  load value.
- CLR_OVF  input  1  clears the OVF flag.
- Q  output  WIDTH  registered count.
- TC  output  1  terminal count, combinational from Q and UP.
- CEO  output  1  cascade enable out, combinational.
- OVF  output  1  registered sticky wrap flag.

## Operation

Q update priority per rising edge is R > L > CE:
- R=1: Q<=0; OVF<=0. L, CE and CLR_OVF are ignored.
- R=0, L=1: Q<=D if D<MODULUS, else Q<=MODULUS-1 (saturating load). CE is ignored; no wrap is generated.
- R=0, L=0, CE=1, UP=1: Q<=Q+1. If Q==MODULUS-1, Q<=0 (wrap).
- R=0, L=0, CE=1, UP=0: Q<=Q-1. If Q==0, Q<=MODULUS-1 (wrap).
- Otherwise Q holds.
- Q must never leave 0..MODULUS-1.
- When MODULUS==2^WIDTH, natural binary overflow/underflow must equal the explicit wrap.

TC and CEO:
- TC = (UP & Q==MODULUS-1) | (~UP & Q==0).
- CEO = TC & CE & ~L & ~R. CEO is high exactly in cycles where this stage wraps on the next edge.

OVF:
- Set when a wrap occurs (the CEO condition is true at the edge).
- Cleared by CLR_OVF=1 when no wrap occurs that cycle.
- If wrap and CLR_OVF coincide, set wins and OVF=1.
- R clears OVF unconditionally.

Direction: UP may change on any cycle and takes effect at the next edge. TC follows UP combinationally in the same cycle.

## Timing

- Q and OVF are updated on the rising edge of CLK only. There is no asynchronous path.
- Latency: CE/L/R sampled at edge k are reflected on Q after edge k.
- TC and CEO are combinational: valid in the same cycle as their inputs, with no register stage.
- Cascade: N chained stages advance in the same edge. Ripple is combinational through the CEO chain and its depth is linear in N.
- Reset values:
  - Q=0, OVF=0.
  - TC=0 if UP=1; TC=1 if UP=0.
  - CEO=0 while R=1.
- Reset mid-count: the next edge forces Q=0 and OVF=0, regardless of L/CE. Counting resumes from 0 on the first edge with R=0 and CE=1.
- Load at terminal count with CE=1: the load wins, no wrap, OVF unchanged, CEO=0 that cycle.
- Between reset release and the first edge, outputs hold reset values.

## Test plan

Bench configuration: WIDTH=4, MODULUS=10 unless noted.

1. Reset, then CE=1, UP=1 for 12 cycles: Q follows 0,1,…,9,0,1. TC=1 and CEO=1 only in the Q=9 cycle. OVF becomes 1 after the 9→0 edge and stays 1.
2. UP=0, CE=1 from Q=0: Q goes 9,8,…; TC=1 at Q=0. OVF sets on the 0→9 wrap. Toggling UP at Q=5 gives TC=0 in both directions and reverses the count.
3. Load: L=1 with D=7 gives Q=7. L=1 with D=13 gives Q=9 (saturation). L=1 with CE=1 at Q=9, UP=1: Q=D, OVF unchanged, CEO=0.
4. Sticky flag: CLR_OVF=1 alone clears OVF. CLR_OVF=1 in the same cycle as a 9→0 wrap leaves OVF=1. R=1 with CE=1 at Q=9 gives Q=0, OVF=0, CEO=0.
5. Cascade: two instances, CEO0→CE1, both up, MODULUS=10, counting from 00 for 120 cycles. The pair reads 00..99 then 00, and stage-1 OVF sets after cycle 100.
6. Full-range config WIDTH=8, MODULUS=256: 255+1 wraps to 0 and 0−1 wraps to 255. TC, CEO and OVF behave as in scenarios 1–2. Random CE/UP/L stimulus over 10k cycles matches a reference model.
